// File: rtl/mac_rx_pkg.sv
// Shared definitions for the RMII receive filter: FSM states, status bit
// positions, CRC-32 constants and the byte-wise reflected CRC update.
package mac_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_DMAC       = 3'd1,
      ST_SMAC       = 3'd2,
      ST_TYPE       = 3'd3,
      ST_PAYLOAD    = 3'd4,
      ST_DROP       = 3'd5,
      ST_FINISH     = 3'd6,
      ST_FINISH_ADD = 3'd7
   } state_t;

   // Bit positions inside om_status
   localparam int unsigned DMAC_ERR = 32'd0;
   localparam int unsigned TYPE_ERR = 32'd1;
   localparam int unsigned LEN_ERR  = 32'd2;
   localparam int unsigned FCS_ERR  = 32'd3;

   localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [47:0] BCAST_ADDR  = 48'hFFFF_FFFF_FFFF;

   // One byte of the LSB-first (reflected) CRC-32; the polynomial is mirrored
   // on the fly so only the textbook form needs to be written down.
   function automatic logic [31:0] crc32_upd(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] poly_refl;
      logic [31:0] c;
      for (int i = 0; i < 32; i++) begin
         poly_refl[i] = CRC_POLY[31 - i];
      end
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) begin
            c = {1'b0, c[31:1]} ^ poly_refl;
         end else begin
            c = {1'b0, c[31:1]};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/mac_rx_filter_crc32_d8.sv
// Byte-serial CRC-32 accumulator (reflected, preset to all-ones). The register
// is not inverted at the end, so a frame with a correct FCS leaves CRC_RESIDUE.
module crc32_d8
   import mac_rx_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [7:0]  im_byte,
   output logic [31:0] om_crc
);

   logic [31:0] crc_r;

   // Preset on reset or new frame, fold in one byte per enabled strobe
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         crc_r <= CRC_INIT;
      end else if (i_en) begin
         crc_r <= crc32_upd(crc_r, im_byte);
      end else begin
         crc_r <= crc_r;
      end
   end

   assign om_crc = crc_r;

endmodule

// File: rtl/mac_rx_filter.sv
// RMII receive filter: checks DMAC and EtherType, writes the payload into a
// dual-port buffer and reports length/status per frame.
// Optional FCS check enabled by defining MAC_RX_FCS_CHK_EN.
module mac_rx_filter
   import mac_rx_pkg::*;
#(
   parameter int          ADDR_W        = 11,
   parameter int          MAX_PAYLOAD   = 1500,
   parameter int          MIN_PAYLOAD   = 46,
   parameter logic [15:0] TYPE_PROTOCOL = 16'h008A,
   parameter bit          BCAST_ACCEPT  = 1'b1
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_frm_start,
   input  logic              i_frm_act,
   input  logic              i_byte_vld,
   input  logic [7:0]        im_byte,
   input  logic [47:0]       im_dmac_addr,
   output logic              o_wren,
   output logic [ADDR_W-1:0] om_wraddr,
   output logic [7:0]        om_wrdata,
   output logic              o_done,
   output logic [ADDR_W-1:0] om_len,
   output logic [3:0]        om_status,
   output logic              o_data_ready
);

`ifdef MAC_RX_FCS_CHK_EN
   localparam int FCS_N = 4;
`else
   localparam int FCS_N = 0;
`endif
   // Buffer write limit: the FCS bytes are stored on top of MAX_PAYLOAD
   localparam logic [ADDR_W-1:0] LIMIT_L = ADDR_W'(MAX_PAYLOAD + FCS_N);
   localparam logic [ADDR_W-1:0] MIN_L   = ADDR_W'(MIN_PAYLOAD);

   state_t            state_r;
   logic              frm_act_d_r;
   logic [47:0]       hdr_r;
   logic [2:0]        hdr_cnt_r;
   logic [ADDR_W-1:0] cnt_r;
   logic [3:0]        err_r;
   logic              pl_seen_r;
   logic              wren_r;
   logic [ADDR_W-1:0] wraddr_r;
   logic [7:0]        wrdata_r;
   logic              done_r;
   logic [ADDR_W-1:0] len_r;
   logic [3:0]        status_r;
   logic              ready_r;

   logic              fall_s;
   logic [47:0]       hdr_cand_s;
   logic              dmac_ok_s;
   logic              type_ok_s;
   logic [ADDR_W-1:0] len_s;
   logic              fcs_bad_s;
   logic [3:0]        fin_status_s;

   assign fall_s     = frm_act_d_r & ~i_frm_act;
   assign hdr_cand_s = {hdr_r[39:0], im_byte};
   assign dmac_ok_s  = (hdr_cand_s == im_dmac_addr) || (BCAST_ACCEPT && (hdr_cand_s == BCAST_ADDR));
   assign type_ok_s  = (hdr_cand_s[15:0] == TYPE_PROTOCOL);

`ifdef MAC_RX_FCS_CHK_EN
   logic        crc_en_s;
   logic [31:0] crc_s;

   // CRC covers every header and payload byte that the FSM accepts
   always_comb begin
      crc_en_s = 1'b0;
      case (state_r)
         ST_DMAC, ST_SMAC, ST_TYPE: crc_en_s = i_byte_vld & ~i_frm_start & ~fall_s;
         ST_PAYLOAD:                crc_en_s = i_byte_vld & ~i_frm_start & ~fall_s & (cnt_r < LIMIT_L);
         default:                   crc_en_s = 1'b0;
      endcase
   end

   crc32_d8 u_crc (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (i_frm_start),
      .i_en    (crc_en_s),
      .im_byte (im_byte),
      .om_crc  (crc_s)
   );
`endif

   // Final length and status presented when the frame closes
   always_comb begin
      len_s     = cnt_r;
      fcs_bad_s = 1'b0;
`ifdef MAC_RX_FCS_CHK_EN
      len_s     = (cnt_r >= ADDR_W'(FCS_N)) ? (cnt_r - ADDR_W'(FCS_N)) : {ADDR_W{1'b0}};
      // An overflowed frame is already bad; its CRC stopped with the writes
      fcs_bad_s = pl_seen_r & ~err_r[LEN_ERR] & (crc_s != CRC_RESIDUE);
`endif
      fin_status_s          = err_r;
      fin_status_s[LEN_ERR] = err_r[LEN_ERR] | (pl_seen_r & (len_s < MIN_L));
      fin_status_s[FCS_ERR] = err_r[FCS_ERR] | fcs_bad_s;
   end

   // Frame parser FSM with all outputs registered
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r     <= ST_IDLE;
         frm_act_d_r <= 1'b0;
         hdr_r       <= 48'h0;
         hdr_cnt_r   <= 3'd0;
         cnt_r       <= {ADDR_W{1'b0}};
         err_r       <= 4'b0000;
         pl_seen_r   <= 1'b0;
         wren_r      <= 1'b0;
         wraddr_r    <= {ADDR_W{1'b0}};
         wrdata_r    <= 8'h00;
         done_r      <= 1'b0;
         len_r       <= {ADDR_W{1'b0}};
         status_r    <= 4'b0000;
         ready_r     <= 1'b0;
      end else begin
         frm_act_d_r <= i_frm_act;
         done_r      <= 1'b0;
         wren_r      <= 1'b0;
         if (i_frm_start) begin
            // New SFD wins over anything in flight; pending write is flushed
            state_r   <= ST_DMAC;
            hdr_cnt_r <= 3'd0;
            cnt_r     <= {ADDR_W{1'b0}};
            err_r     <= 4'b0000;
            pl_seen_r <= 1'b0;
            ready_r   <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  ready_r <= 1'b0;
               end
               ST_DMAC: begin
                  if (fall_s) begin
                     err_r[LEN_ERR] <= 1'b1;
                     state_r        <= ST_FINISH;
                  end else if (i_byte_vld) begin
                     hdr_r <= hdr_cand_s;
                     if (hdr_cnt_r == 3'd5) begin
                        hdr_cnt_r <= 3'd0;
                        if (dmac_ok_s) begin
                           state_r <= ST_SMAC;
                        end else begin
                           err_r[DMAC_ERR] <= 1'b1;
                           state_r         <= ST_DROP;
                        end
                     end else begin
                        hdr_cnt_r <= hdr_cnt_r + 3'd1;
                     end
                  end
               end
               ST_SMAC: begin
                  if (fall_s) begin
                     err_r[LEN_ERR] <= 1'b1;
                     state_r        <= ST_FINISH;
                  end else if (i_byte_vld) begin
                     if (hdr_cnt_r == 3'd5) begin
                        hdr_cnt_r <= 3'd0;
                        state_r   <= ST_TYPE;
                     end else begin
                        hdr_cnt_r <= hdr_cnt_r + 3'd1;
                     end
                  end
               end
               ST_TYPE: begin
                  if (fall_s) begin
                     err_r[LEN_ERR] <= 1'b1;
                     state_r        <= ST_FINISH;
                  end else if (i_byte_vld) begin
                     hdr_r <= hdr_cand_s;
                     if (hdr_cnt_r == 3'd1) begin
                        hdr_cnt_r <= 3'd0;
                        if (type_ok_s) begin
                           pl_seen_r <= 1'b1;
                           state_r   <= ST_PAYLOAD;
                        end else begin
                           err_r[TYPE_ERR] <= 1'b1;
                           state_r         <= ST_DROP;
                        end
                     end else begin
                        hdr_cnt_r <= hdr_cnt_r + 3'd1;
                     end
                  end
               end
               ST_PAYLOAD: begin
                  if (fall_s) begin
                     state_r <= ST_FINISH;
                  end else if (i_byte_vld) begin
                     if (cnt_r < LIMIT_L) begin
                        wren_r   <= 1'b1;
                        wraddr_r <= cnt_r;
                        wrdata_r <= im_byte;
                        cnt_r    <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                     end else begin
                        err_r[LEN_ERR] <= 1'b1;
                        state_r        <= ST_DROP;
                     end
                  end
               end
               ST_DROP: begin
                  if (!i_frm_act) begin
                     state_r <= ST_FINISH;
                  end
               end
               ST_FINISH: begin
                  done_r   <= 1'b1;
                  len_r    <= len_s;
                  status_r <= fin_status_s;
                  ready_r  <= (fin_status_s == 4'b0000);
                  state_r  <= ST_FINISH_ADD;
               end
               ST_FINISH_ADD: begin
                  state_r <= ST_IDLE;
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_wren       = wren_r;
   assign om_wraddr    = wraddr_r;
   assign om_wrdata    = wrdata_r;
   assign o_done       = done_r;
   assign om_len       = len_r;
   assign om_status    = status_r;
   assign o_data_ready = ready_r;

endmodule

// File: doc/mac_rx_filter.md
Name: mac_rx_filter

Overview:
- Parametrised successor to the fixed-length RMII MAC receive parser.
- Consumes the byte stream from the RMII decoder (frame-active, byte strobe, byte).
- Filters on DMAC (unicast plus optional broadcast) and EtherType; accepts variable-length payloads.
- Writes payload bytes to a dual-port buffer, then reports per-frame length and error status to the protocol layer.

Parameters:
- ADDR_W, 11: payload write-address width.
- MAX_PAYLOAD, 1500: maximum payload bytes written; further bytes are discarded and flagged.
- MIN_PAYLOAD, 46: payload below this count sets len_err.
- TYPE_PROTOCOL, 16'h008A: accepted EtherType, received MSB first.
- BCAST_ACCEPT, 1: 1 = DMAC 48'hFFFF_FFFF_FFFF is also accepted.

Ports:
- i_clk  in  1  system clock (50 MHz RMII domain)
- i_rst  in  1  synchronous reset, active-high
- i_frm_start  in  1  1-cycle pulse at SFD detection
- i_frm_act  in  1  high while frame bytes are arriving; falling edge = frame end
- i_byte_vld  in  1  1-cycle strobe, im_byte valid
- im_byte  in  8  received byte
- im_dmac_addr  in  48  own MAC address, quasi-static
- o_wren  out  1  payload buffer write enable
- om_wraddr  out  ADDR_W  payload write address
- om_wrdata  out  8  payload write data
- o_done  out  1  1-cycle pulse, frame finished (good or bad)
- om_len  out  ADDR_W  payload byte count, valid with o_done
- om_status  out  4  {fcs_err, len_err, type_err, dmac_err}, valid with o_done
- o_data_ready  out  1  high 2 cycles after a good frame

Behaviour:
- Reset: state IDLE; all outputs 0; counters and address 0.
- States: IDLE, DMAC, SMAC, TYPE, PAYLOAD, DROP, FINISH, FINISH_ADD.
- IDLE -> DMAC on i_frm_start.
- DMAC:
  - Shifts 6 bytes into a 48-bit register, MSB first.
  - On the 6th strobe, compares against im_dmac_addr, or all-ones when BCAST_ACCEPT = 1.
  - Match -> SMAC. Mismatch -> DROP with dmac_err.
- SMAC: counts 6 bytes, then -> TYPE.
- TYPE:
  - Shifts 2 bytes.
  - After the 2nd byte, mismatch with TYPE_PROTOCOL -> DROP with type_err; match -> PAYLOAD.
- PAYLOAD:
  - Each strobe writes the byte at the current count, then the count increments.
  - Write outputs are registered: 1-cycle latency from i_byte_vld to o_wren/om_wraddr/om_wrdata.
  - The first payload byte is written to address 0.
  - Once the count reaches MAX_PAYLOAD, writes stop, len_err is set and the state -> DROP.
- i_frm_act falling:
  - In PAYLOAD or DROP -> FINISH.
  - In DMAC/SMAC/TYPE (truncated header) -> FINISH with len_err.
- DROP: no writes; waits for i_frm_act low, then -> FINISH.
- FINISH:
  - o_done = 1 for one cycle.
  - om_len = payload count (saturated at MAX_PAYLOAD). om_len and om_status hold until the next o_done.
  - len_err is also set if count < MIN_PAYLOAD.
  - o_data_ready = 1 when om_status == 0. Then -> FINISH_ADD.
- FINISH_ADD: o_data_ready held if the frame was good; -> IDLE.
- i_frm_start in any non-IDLE state:
  - Aborts the current frame with no o_done; state -> DMAC.
  - Error flags clear; count clears; write pipe flushes.
- i_byte_vld outside DMAC/SMAC/TYPE/PAYLOAD is ignored.
- i_rst mid-frame: immediate IDLE; any pending registered write is dropped.
- Error flags clear on i_frm_start only; multiple flags may be set together.

Optional Feature:
- Macro: MAC_RX_FCS_CHK_EN
- Defined:
  - A CRC-32 (poly 04C11DB7, reflected, init all-ones) runs over DMAC through the last byte.
  - At FINISH, a residue other than 32'hDEBB20E3 sets fcs_err.
  - om_len excludes the 4 FCS bytes; the FCS bytes are still written to the buffer.
  - The MIN/MAX checks use the FCS-excluded length.
- Undefined: no CRC logic; fcs_err is tied 0; om_len counts every byte after TYPE.

Decomposition:
- Package mac_rx_pkg:
  - state encodings
  - status bit indices (DMAC_ERR = 0, TYPE_ERR = 1, LEN_ERR = 2, FCS_ERR = 3)
  - CRC polynomial and residue constants
  - broadcast address constant
- Sub-module crc32_d8: 8-bit-per-strobe CRC-32 update, instantiated only under MAC_RX_FCS_CHK_EN.

Test Plan:
- Good frame, DMAC = im_dmac_addr 48'h0011_2233_4455, type 16'h008A, 138-byte payload 0x00..0x89 -> 138 writes at addr 0..137 with data = addr; om_len = 138; om_status = 0; o_done 1 cycle; o_data_ready 2 cycles.
- DMAC 48'h0011_2233_4456 -> no writes; o_done with om_status = 4'b0001; o_data_ready stays 0. Repeat with DMAC all-ones and BCAST_ACCEPT = 1 -> accepted.
- Type 16'h0800 -> no writes; om_status = 4'b0010.
- 20-byte payload -> om_status = 4'b0100, om_len = 20. 1600-byte payload -> exactly 1500 writes (last addr 1499), om_len = 1500, len_err set.
- i_frm_start mid-PAYLOAD at byte 50, then a good 64-byte frame -> single o_done with om_len = 64, status 0. i_rst at payload byte 10 -> all outputs 0 the next cycle.
- MAC_RX_FCS_CHK_EN: 64-byte payload + correct FCS -> om_len = 64, status 0. Same frame with one payload bit flipped -> om_status = 4'b1000.
